store_merge_unit: RTL
=====================

# store_merge_unit

Store-side counterpart of the processor's load byte-extraction path. Accepts word and byte store requests from the core and writes them to a word-organised data memory. Byte stores use a read-modify-write sequence that replaces exactly one byte lane. Lane numbering matches the load path: offset 0 is bits 7:0 and offset 3 is bits 31:24. The unit sits between the execute/memory stage and the data memory port.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of `addr` and `mem_addr`

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  store request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- addr  input  ADDR_W  byte address of the store
- wdata  input  32  store data; byte stores use wdata[7:0]
- store_select  input  1  0 = word store, 1 = byte store
- done  output  1  one-cycle pulse in the cycle the memory write occurs
- mem_addr  output  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}
- mem_re  output  1  memory read strobe
- mem_rdata  input  32  read data, valid one cycle after mem_re is sampled
- mem_we  output  1  memory write strobe
- mem_wdata  output  32  write data
- mem_be  output  4  byte write enables; exists only with STORE_BYTE_MASK_EN

## Operation
- States: IDLE, RD, WAIT, WR. All outputs are decoded from state and registers only; there are no combinational paths from inputs to outputs.
- Acceptance: a request is accepted when req_valid && req_ready, which is only possible in IDLE. On acceptance the unit registers addr, wdata[31:0], store_select and offset = addr[1:0].
- Word store: IDLE -> WR -> IDLE.
  - In WR: mem_we=1, mem_wdata=registered wdata, done=1.
  - addr[1:0] is ignored; the write is forced to the aligned word.
- Byte store: IDLE -> RD -> WAIT -> WR -> IDLE.
  - In RD: mem_re=1, mem_addr is valid.
  - In WAIT: mem_rdata is captured into the merge register, with lane `offset` replaced by wdata[7:0]. The other three lanes are taken unchanged from mem_rdata.
  - In WR: mem_we=1, mem_wdata=merged word, done=1.
- mem_addr holds the registered aligned address from acceptance until returning to IDLE. In IDLE it holds its last value.
- mem_re and mem_we are never asserted in the same cycle.
- Reset values: state=IDLE, req_ready=1, done=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, all internal registers 0.
- Reset mid-operation (any state): the unit returns to IDLE asynchronously. mem_we and mem_re drop immediately and no write is issued. A partially merged word is discarded.
- A request presented while the unit is busy is held off by req_ready=0. It is not lost as long as the requester holds req_valid.

## Timing
- Cycle numbering: cycle 0 is the acceptance edge.
- Word store: WR in cycle 1, so done and mem_we occur 1 cycle after acceptance. req_ready rises again in cycle 2.
- Byte store:
  - RD in cycle 1.
  - WAIT in cycle 2; mem_rdata is sampled at the end of cycle 2.
  - WR in cycle 3, with done and mem_we.
  - req_ready rises again in cycle 4.
- Back-to-back throughput: one word store every 2 cycles; one byte store every 4 cycles.
- done is high for exactly one cycle per accepted request.

## Configuration
- Macro: STORE_BYTE_MASK_EN.
- Defined:
  - The mem_be[3:0] port exists.
  - Byte stores go IDLE -> WR directly, with the same latency as a word store.
  - mem_be is one-hot on lane `offset`.
  - mem_wdata carries wdata[7:0] in lane `offset`; all other lanes are 0.
  - Word stores drive mem_be=4'hF.
  - mem_re is tied to 0; RD and WAIT are unreachable.
  - mem_be=0 outside WR and on reset.
- Undefined: there is no mem_be port, and byte stores use the full read-modify-write sequence described above.

## Test plan
- Reset release: reset asserted then released. req_ready=1, done=0, mem_we=0, mem_re=0, mem_addr=0.
- Word store: addr=0x100, wdata=0xDEADBEEF, store_select=0. mem_we=1 with mem_addr=0x100, mem_wdata=0xDEADBEEF and done=1 one cycle after acceptance; mem_re never asserted.
- Byte store, all lanes: memory word 0x11223344, wdata=0xAA, addr=0x200..0x203. Writes of 0x112233AA, 0x1122AA44, 0x11AA3344 and 0xAA223344 respectively, each 3 cycles after acceptance.
- Misaligned word store: addr=0x203, wdata=0x01020304. Write to mem_addr=0x200 with 0x01020304.
- Reset mid-operation: reset asserted during WAIT of a byte store. mem_we is never asserted for that request, the state returns to IDLE, and the memory word is unchanged.
- Busy back-pressure: req_valid held high for a second store during a byte store. req_ready=0 until cycle 4, then the second request is accepted and produces exactly one done pulse. With STORE_BYTE_MASK_EN, the byte store to addr=0x202 gives mem_be=4'b0100 and mem_wdata=0x00AA0000 in cycle 1.

Source files
------------

// File: rtl/store_merge_unit.sv
// store_merge_unit
// Store-side partner of the load byte-extraction path. Takes word and byte
// stores from the core and writes them to a word-organised data memory.
// Byte stores normally read the target word, replace one lane and write it
// back. Lane 0 is bits 7:0 and lane 3 is bits 31:24.
//
// Optional feature macro: STORE_BYTE_MASK_EN
//   When defined, the memory port gains byte enables (mem_be). Byte stores then
//   write straight through with a one-hot mask and skip the read phase.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   req_valid/ready    store request handshake (ready only while idle)
//   addr, wdata        byte address and store data (byte stores use wdata[7:0])
//   store_select       0 = word store, 1 = byte store
//   done               one-cycle pulse in the cycle the memory write occurs
//   mem_addr           word-aligned memory address
//   mem_re, mem_rdata  read strobe and read data (data valid one cycle later)
//   mem_we, mem_wdata  write strobe and write data
//   mem_be             byte write enables (STORE_BYTE_MASK_EN only)
module store_merge_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              store_select,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
`ifdef STORE_BYTE_MASK_EN
    ,
    output logic [3:0]        mem_be
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned LANES  = DATA_W / LANE_W;
    localparam int unsigned OFS_W  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WAIT = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nx;

    // Request context captured at acceptance, needed for the merge
    logic [OFS_W-1:0]    offset_q;
    logic [OFS_W-1:0]    offset_nx;
    logic [LANE_W-1:0]   byte_q;
    logic [LANE_W-1:0]   byte_nx;

    // Next values of the registered outputs
    logic                req_ready_nx;
    logic                done_nx;
    logic                mem_re_nx;
    logic                mem_we_nx;
    logic [ADDR_W-1:0]   mem_addr_nx;
    logic [DATA_W-1:0]   mem_wdata_nx;
`ifdef STORE_BYTE_MASK_EN
    logic [LANES-1:0]    mem_be_nx;
`endif

    // Replace lane ofs of word with b, keeping the other lanes
    function automatic logic [DATA_W-1:0] merge_lane(
        input logic [DATA_W-1:0] word,
        input logic [LANE_W-1:0] b,
        input logic [OFS_W-1:0]  ofs
    );
        logic [DATA_W-1:0] r;
        r = word;
        for (int i = 0; i < int'(LANES); i++) begin
            if (ofs == OFS_W'(i)) begin
                r[i*LANE_W +: LANE_W] = b;
            end
        end
        return r;
    endfunction

    // State and captured-context registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            offset_q <= '0;
            byte_q   <= '0;
        end else begin
            state    <= state_nx;
            offset_q <= offset_nx;
            byte_q   <= byte_nx;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nx     = state;
        offset_nx    = offset_q;
        byte_nx      = byte_q;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
`ifdef STORE_BYTE_MASK_EN
        mem_be_nx    = '0;
`endif

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    offset_nx   = addr[OFS_W-1:0];
                    byte_nx     = wdata[LANE_W-1:0];
                    // Low address bits never reach memory; the write is word aligned
                    mem_addr_nx = {addr[ADDR_W-1:OFS_W], OFS_W'(0)};
                    if (store_select) begin
`ifdef STORE_BYTE_MASK_EN
                        state_nx     = S_WR;
                        mem_wdata_nx = DATA_W'(wdata[LANE_W-1:0]) << {addr[OFS_W-1:0], 3'b000};
                        mem_be_nx    = LANES'(1) << addr[OFS_W-1:0];
`else
                        state_nx     = S_RD;
`endif
                    end else begin
                        state_nx     = S_WR;
                        mem_wdata_nx = wdata;
`ifdef STORE_BYTE_MASK_EN
                        mem_be_nx    = '1;
`endif
                    end
                end
            end
            S_RD: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                // Read data is valid now; the merged word becomes the write data
                state_nx     = S_WR;
                mem_wdata_nx = merge_lane(mem_rdata, byte_q, offset_q);
            end
            S_WR: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Strobes are decoded from the upcoming state so they are registered
        req_ready_nx = (state_nx == S_IDLE);
        mem_we_nx    = (state_nx == S_WR);
        done_nx      = (state_nx == S_WR);
`ifdef STORE_BYTE_MASK_EN
        mem_re_nx    = 1'b0;
`else
        mem_re_nx    = (state_nx == S_RD);
`endif
    end

    // Output registers; reset drops the strobes immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready <= 1'b1;
            done      <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            req_ready <= req_ready_nx;
            done      <= done_nx;
            mem_re    <= mem_re_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
        end
    end

`ifdef STORE_BYTE_MASK_EN
    // Byte enables are only non-zero during the write cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_be <= '0;
        end else begin
            mem_be <= mem_be_nx;
        end
    end
`endif

    // Read and write strobes are mutually exclusive
    a_re_we_excl: assert property (@(posedge clk) disable iff (reset) !(mem_re && mem_we));

endmodule
